// File: rtl/mire_wshb_writer.sv
// mire_wshb_writer
// Wishbone classic write master that fills a linear framebuffer with a test
// pattern (mire): a white grid every GRID pixels over eight colour bars.
// One 32-bit word per pixel at byte address 4*(y*HDISP+x). The bus is dropped
// for one cycle after every BURST writes so an arbiter can serve the reader.
//
// Optional build macro: MIRE_CONTINUOUS_EN
//   defined     : frames repeat forever; a GAP cycle follows the last pixel,
//                 and then the fill restarts at address 0.
//   not defined : one frame per start pulse; returns to IDLE after DONE.
//
// Ports
//   clk        in   Wishbone clock
//   rst_n      in   asynchronous reset, active low
//   start      in   start a frame fill (sampled in IDLE only)
//   busy       out  FSM not in IDLE
//   done       out  one-cycle pulse after the last pixel of a frame is acked
//   wb_adr     out  byte address
//   wb_dat_ms  out  write data {8'h00,R,G,B}
//   wb_sel     out  4'b1111
//   wb_we      out  1
//   wb_cyc     out  bus request
//   wb_stb     out  same as wb_cyc
//   wb_cti     out  3'b000
//   wb_bte     out  2'b00
//   wb_ack     in   slave acknowledge
//
// state   | meaning
// S_IDLE  | bus released, waiting for start
// S_WRITE | cyc/stb high, address and data held until ack
// S_GAP   | bus released for one cycle between bursts
// S_DONE  | bus released, done pulse, back to idle
module mire_wshb_writer #(
   parameter int HDISP = 800,
   parameter int VDISP = 480,
   parameter int BURST = 64,
   parameter int GRID  = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [31:0] wb_adr,
   output logic [31:0] wb_dat_ms,
   output logic [3:0]  wb_sel,
   output logic        wb_we,
   output logic        wb_cyc,
   output logic        wb_stb,
   output logic [2:0]  wb_cti,
   output logic [1:0]  wb_bte,
   input  logic        wb_ack
);

   localparam int XW    = (HDISP > 1) ? $clog2(HDISP) : 1;
   localparam int YW    = (VDISP > 1) ? $clog2(VDISP) : 1;
   localparam int BW    = $clog2(BURST);
   localparam int BAR_W = HDISP / 8;
   localparam int CW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

   localparam logic [XW-1:0] X_LAST   = XW'(HDISP - 1);
   localparam logic [YW-1:0] Y_LAST   = YW'(VDISP - 1);
   localparam logic [BW-1:0] B_LAST   = BW'(BURST - 1);
   localparam logic [CW-1:0] BAR_LOAD = CW'(BAR_W - 1);
   localparam logic [XW-1:0] X_MASK   = XW'(GRID - 1);
   localparam logic [YW-1:0] Y_MASK   = YW'(GRID - 1);

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_GAP, S_DONE} state_t;

   state_t          state, state_nx;
   logic [XW-1:0]   x, x_nx;
   logic [YW-1:0]   y, y_nx;
   logic [3:0]      bar, bar_nx;
   logic [CW-1:0]   bar_cnt, bar_cnt_nx;
   logic [BW-1:0]   burst_cnt;
   logic [31:0]     adr;
   logic [23:0]     dat;
   logic            done_r;
   logic            acked, last_px, burst_end;

   function automatic logic [23:0] pattern(input logic [XW-1:0] px,
                                           input logic [YW-1:0] py,
                                           input logic [3:0]    pbar);
      logic [23:0] rgb;
      if (((px & X_MASK) == '0) || ((py & Y_MASK) == '0)) begin
         rgb = 24'hFFFFFF;
      end else begin
         case (pbar)
            4'd0:    rgb = 24'hFFFFFF;
            4'd1:    rgb = 24'hFFFF00;
            4'd2:    rgb = 24'h00FFFF;
            4'd3:    rgb = 24'h00FF00;
            4'd4:    rgb = 24'hFF00FF;
            4'd5:    rgb = 24'hFF0000;
            4'd6:    rgb = 24'h0000FF;
            default: rgb = 24'h000000;
         endcase
      end
      return rgb;
   endfunction

   assign acked     = (state == S_WRITE) && wb_ack;
   assign last_px   = (x == X_LAST) && (y == Y_LAST);
   assign burst_end = (burst_cnt == B_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start) state_nx = S_WRITE;
         S_WRITE: begin
            if (wb_ack) begin
               if (last_px) begin
`ifdef MIRE_CONTINUOUS_EN
                  state_nx = S_GAP;
`else
                  state_nx = S_DONE;
`endif
               end else if (burst_end) begin
                  state_nx = S_GAP;
               end
            end
         end
         S_GAP:   state_nx = S_WRITE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Next-pixel coordinates and bar position; the bar counter counts down the
   // pixels left in the current bar so no divider is needed.
   always_comb begin
      x_nx       = x + 1'b1;
      y_nx       = y;
      bar_nx     = bar;
      bar_cnt_nx = bar_cnt - 1'b1;
      if (x == X_LAST) begin
         x_nx       = '0;
         y_nx       = (y == Y_LAST) ? '0 : y + 1'b1;
         bar_nx     = 4'd0;
         bar_cnt_nx = BAR_LOAD;
      end else if (bar_cnt == '0) begin
         bar_cnt_nx = BAR_LOAD;
         if (bar != 4'd8) bar_nx = bar + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x         <= '0;
         y         <= '0;
         bar       <= 4'd0;
         bar_cnt   <= BAR_LOAD;
         burst_cnt <= '0;
         adr       <= '0;
         dat       <= '0;
         done_r    <= 1'b0;
      end else begin
         done_r <= acked && last_px;
         if ((state == S_IDLE) && start) begin
            x         <= '0;
            y         <= '0;
            bar       <= 4'd0;
            bar_cnt   <= BAR_LOAD;
            burst_cnt <= '0;
            adr       <= '0;
            dat       <= pattern('0, '0, 4'd0);
         end else if (acked) begin
            x         <= x_nx;
            y         <= y_nx;
            bar       <= bar_nx;
            bar_cnt   <= bar_cnt_nx;
            burst_cnt <= (burst_end || last_px) ? '0 : burst_cnt + 1'b1;
            adr       <= last_px ? 32'd0 : adr + 32'd4;
            dat       <= pattern(x_nx, y_nx, bar_nx);
         end
      end
   end

   assign busy      = (state != S_IDLE);
   assign done      = done_r;
   assign wb_cyc    = (state == S_WRITE);
   assign wb_stb    = wb_cyc;
   assign wb_adr    = adr;
   assign wb_dat_ms = {8'h00, dat};
   assign wb_sel    = 4'b1111;
   assign wb_we     = 1'b1;
   assign wb_cti    = 3'b000;
   assign wb_bte    = 2'b00;

endmodule

// File: tb/tb_mire_wshb_writer.sv
// Bench for mire_wshb_writer with a small 16x4 frame, bursts of 8, grid 4.
// Expected addresses and pixels come from a plain arithmetic model of the
// frame; a random-wait slave checks bus stability and burst gaps.
module tb_mire_wshb_writer;
   localparam int HDISP = 16;
   localparam int VDISP = 4;
   localparam int BURST = 8;
   localparam int GRID  = 4;
   localparam int NPIX  = HDISP * VDISP;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        busy, done;
   logic [31:0] wb_adr, wb_dat_ms;
   logic [3:0]  wb_sel;
   logic        wb_we, wb_cyc, wb_stb;
   logic [2:0]  wb_cti;
   logic [1:0]  wb_bte;
   logic        wb_ack;

   int checks = 0;
   int errors = 0;

   mire_wshb_writer #(.HDISP(HDISP), .VDISP(VDISP), .BURST(BURST), .GRID(GRID)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .wb_adr(wb_adr), .wb_dat_ms(wb_dat_ms), .wb_sel(wb_sel), .wb_we(wb_we),
      .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_cti(wb_cti), .wb_bte(wb_bte),
      .wb_ack(wb_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_pixel(input int idx);
      int px = idx % HDISP;
      int py = idx / HDISP;
      int bw = HDISP / 8;
      if ((px % GRID == 0) || (py % GRID == 0)) return 32'h00FFFFFF;
      if (px >= 8 * bw) return 32'h0;
      case (px / bw)
         0: return 32'h00FFFFFF;
         1: return 32'h00FFFF00;
         2: return 32'h0000FFFF;
         3: return 32'h0000FF00;
         4: return 32'h00FF00FF;
         5: return 32'h00FF0000;
         6: return 32'h000000FF;
         default: return 32'h0;
      endcase
   endfunction

   task automatic reset_now(input string tag);
      rst_n = 1'b0;
      #1;
      chk({tag, "_cyc"},  wb_cyc, 0);
      chk({tag, "_stb"},  wb_stb, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_adr"},  wb_adr, 0);
      start  = 1'b0;
      wb_ack = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Runs `frames` frames (or stops right after ack number stop_at, leaving the
   // clock high phase in progress) with 0..max_wait wait states per transfer.
   task automatic run_frame(input int max_wait, input int stop_at, input int frames);
      int          n = 0;
      int          wait_left;
      logic        holding = 1'b0;
      logic        gap_next = 1'b0, end_next = 1'b0, fin = 1'b0;
      logic [31:0] h_adr = '0, h_dat = '0;
      @(negedge clk);
      start  = 1'b1;
      wb_ack = 1'b0;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      wait_left = $urandom_range(0, max_wait);
      for (int cyc_i = 0; cyc_i < 4000 && !fin; cyc_i++) begin
         if (end_next) begin
            end_next = 1'b0;
            start    = 1'b0;
            wb_ack   = 1'b0;
            chk("done_pulse", done, 1);
            chk("cyc_low_at_end", wb_cyc, 0);
`ifdef MIRE_CONTINUOUS_EN
            chk("busy_cont", busy, 1);
            if (n == frames * NPIX) fin = 1'b1;
`else
            @(negedge clk);
            chk("done_one_cycle", done, 0);
            chk("idle_busy", busy, 0);
            chk("idle_cyc", wb_cyc, 0);
            fin = 1'b1;
`endif
         end else if (gap_next) begin
            gap_next = 1'b0;
            chk("gap_cyc", wb_cyc, 0);
            chk("gap_done", done, 0);
            wb_ack = 1'($urandom);
            start  = 1'($urandom);
         end else begin
            chk("cyc_high", wb_cyc, 1);
            chk("stb_high", wb_stb, 1);
            if (holding) begin
               chk("adr_stable", wb_adr, h_adr);
               chk("dat_stable", wb_dat_ms, h_dat);
            end
            if (wait_left == 0) begin
               wb_ack = 1'b1;
               chk($sformatf("adr[%0d]", n % NPIX), wb_adr, 32'(4 * (n % NPIX)));
               chk($sformatf("dat[%0d]", n % NPIX), wb_dat_ms, ref_pixel(n % NPIX));
               n++;
               holding   = 1'b0;
               end_next  = (n % NPIX == 0);
               gap_next  = !end_next && (n % BURST == 0);
               wait_left = $urandom_range(0, max_wait);
            end else begin
               wb_ack  = 1'b0;
               wait_left--;
               holding = 1'b1;
               h_adr   = wb_adr;
               h_dat   = wb_dat_ms;
            end
            start = 1'($urandom);
         end
         if (stop_at >= 0 && n == stop_at && wb_ack && !fin) begin
            @(posedge clk);
            #2;
            fin = 1'b1;
         end else if (!fin) begin
            @(negedge clk);
         end
      end
      if (!fin) chk("timeout", 0, 1);
      start  = 1'b0;
      wb_ack = 1'b0;
   endtask

   initial begin
      rst_n  = 1'b0;
      start  = 1'b0;
      wb_ack = 1'b0;
      #1;
      chk("rst_cyc", wb_cyc, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_adr", wb_adr, 0);
      chk("rst_sel", wb_sel, 4'hF);
      chk("rst_we", wb_we, 1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

`ifdef MIRE_CONTINUOUS_EN
      run_frame(0, -1, 3);
      reset_now("cont_rst");
      run_frame(2, -1, 2);
      reset_now("cont_rst2");
`else
      run_frame(0, -1, 1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         wb_ack = 1'($urandom);
         chk("idle_ack_ignored", wb_cyc, 0);
      end
      wb_ack = 1'b0;
      run_frame(3, -1, 1);
      run_frame(1, 20, 1);
      reset_now("mid_rst");
      @(negedge clk);
      chk("no_restart_busy", busy, 0);
      run_frame(0, -1, 1);
      chk("cti", wb_cti, 0);
      chk("bte", wb_bte, 0);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
